// File: rtl/logic_gate_arbiter_if.sv
// logic_gate_arbiter_if: request and response channels of the logic arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface logic_gate_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [3*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [WIDTH-1:0]       resp_y;
  logic                   resp_err;
  logic [15:0]            ops_done;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_err,
    input  ops_done
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_err,
    output ops_done
  );
endinterface

// File: rtl/logic_gate_arbiter.sv
// logic_gate_arbiter: round-robin share of one registered bitwise logic unit.
// Ports: clk, rst (sync active-high), bus (slave: req_* in, resp_* out).
module logic_gate_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_gate_arbiter_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             gnt_found;
  logic             slot_free;
  logic             accept;
  logic             drain;
  logic [2:0]       g_op;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_b;
  logic [WIDTH-1:0] g_y;
  logic             g_err;

  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_y;
  logic             r_err;
  logic [15:0]      r_ops;

  // First valid index at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign slot_free = !r_valid || bus.resp_ready;
  assign accept    = gnt_found && slot_free && !rst;
  assign drain     = r_valid && bus.resp_ready;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    g_op = '0;
    g_a  = '0;
    g_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == gnt_idx) begin
        g_op = bus.req_op[3*k +: 3];
        g_a  = bus.req_a[WIDTH*k +: WIDTH];
        g_b  = bus.req_b[WIDTH*k +: WIDTH];
      end
    end
  end

  always_comb begin
    g_y   = '0;
    g_err = 1'b0;
    unique case (g_op)
      OP_AND:  g_y = g_a & g_b;
      OP_OR:   g_y = g_a | g_b;
      OP_NOT:  g_y = ~g_a;
      OP_NOR:  g_y = ~(g_a | g_b);
      OP_NAND: g_y = ~(g_a & g_b);
      OP_XOR:  g_y = g_a ^ g_b;
      OP_XNOR: g_y = ~(g_a ^ g_b);
      OP_ILL:  g_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_ops   <= '0;
      rr_ptr  <= '0;
    end else begin
      if (drain) r_ops <= r_ops + 16'd1;
      if (accept) begin
        r_valid <= 1'b1;
        r_id    <= gnt_idx;
        r_y     <= g_y;
        r_err   <= g_err;
        rr_ptr  <= (gnt_idx == IDW'(N_REQ - 1)) ?
                   '0 : gnt_idx + 1'b1;
      end else if (drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = r_valid;
  assign bus.resp_id    = r_id;
  assign bus.resp_y     = r_y;
  assign bus.resp_err   = r_err;
  assign bus.ops_done   = r_ops;
endmodule

// File: tb/tb_logic_gate_arbiter.sv
// tb_logic_gate_arbiter: scoreboard bench for logic_gate_arbiter.
// Negedge monitor predicts grants/results; directed phases drive stimulus.
module tb_logic_gate_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  logic_gate_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] golden(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] r;
    r = '0;
    case (op)
      3'd0: r[7:0] = a & b;
      3'd1: r[7:0] = a | b;
      3'd2: r[7:0] = ~a;
      3'd3: r[7:0] = ~(a | b);
      3'd4: r[7:0] = ~(a & b);
      3'd5: r[7:0] = a ^ b;
      3'd6: r[7:0] = ~(a ^ b);
      default: r[8] = 1'b1;
    endcase
    return r;
  endfunction

  logic [31:0] sb[$];
  int          glog[$];
  logic        m_full = 1'b0;
  int          m_rr = 0;
  logic [15:0] m_ops = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] snap = '0;

  // Inputs only change at posedge+1, so the negedge view
  // is exactly what the next rising edge will sample.
  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    logic [31:0]  cur;
    logic [31:0]  e;
    logic         hold_now;
    int           g;
    int           idx;
    if (rst) begin
      check("rdy_in_rst", 32'(bus.req_ready), 32'd0);
      sb.delete();
      m_full    = 1'b0;
      m_rr      = 0;
      m_ops     = '0;
      hold_prev = 1'b0;
    end else begin
      check("resp_valid", 32'(bus.resp_valid), 32'(m_full));
      check("ops_done", 32'(bus.ops_done), 32'(m_ops));
      cur = (32'(bus.resp_id) << 9) | (32'(bus.resp_err) << 8) |
            32'(bus.resp_y);
      if (hold_prev) check("hold", cur, snap);
      hold_now = m_full && !bus.resp_ready;
      e_rdy = '0;
      g = -1;
      if (!m_full || bus.resp_ready) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) e_rdy[g] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      if (m_full && bus.resp_ready) begin
        if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
        else check("resp", cur, sb.pop_front());
        m_ops  = m_ops + 16'd1;
        m_full = 1'b0;
      end
      if (g >= 0) begin
        e = (32'(g) << 9) |
            32'(golden(bus.req_op[3*g +: 3],
                       bus.req_a[W*g +: W],
                       bus.req_b[W*g +: W]));
        sb.push_back(e);
        m_full = 1'b1;
        m_rr   = (g + 1) % N;
        glog.push_back(g);
      end
      hold_prev = hold_now;
      snap      = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[W*i +: W]  = a;
    bus.req_b[W*i +: W]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] sweep_y [8];
  int         rr_exp  [6];

  initial begin
    sweep_y = '{8'h00, 8'hFF, 8'h3A, 8'h00,
                8'hFF, 8'hFF, 8'h00, 8'h00};
    rr_exp  = '{0, 1, 2, 3, 0, 1};
    bus.req_valid  = '1;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'(i), 8'h10);

    // Reset with all requesters valid
    tick();
    tick();
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_id", 32'(bus.resp_id), 32'd0);
    check("rst_y", 32'(bus.resp_y), 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_ops", 32'(bus.ops_done), 32'd0);
    check("rst_rdy", 32'(bus.req_ready), 32'd0);

    // Round-robin: first grant after release is 0
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    glog.delete();
    repeat (6) tick();
    bus.req_valid = '0;
    tick();
    check("rr_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check("rr_order", 32'(glog[i]), 32'(rr_exp[i]));

    // Opcode sweep on requester 1
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_req(1, 3'(k), 8'hC5, 8'h3A);
      bus.req_valid = 4'b0010;
      tick();
      check("sweep_y", 32'(bus.resp_y), 32'(sweep_y[k]));
      check("sweep_id", 32'(bus.resp_id), 32'd1);
      check("sweep_err", 32'(bus.resp_err), (k == 7) ? 32'd1 : 32'd0);
    end
    bus.req_valid = '0;
    tick();
    check("sweep_ops", 32'(bus.ops_done), 32'd8);

    // Backpressure
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    bus.req_valid = 4'b0001;
    tick();
    check("bp_first", 32'(bus.resp_y), 32'h30);
    set_req(1, 3'd1, 8'h0F, 8'h10);
    bus.req_valid = 4'b0010;
    repeat (5) begin
      tick();
      check("bp_y", 32'(bus.resp_y), 32'h30);
      check("bp_id", 32'(bus.resp_id), 32'd0);
      check("bp_rdy", 32'(bus.req_ready), 32'd0);
      check("bp_ops", 32'(bus.ops_done), 32'd0);
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(bus.req_ready), 32'b0010);
    tick();
    check("bp_next_id", 32'(bus.resp_id), 32'd1);
    check("bp_next_y", 32'(bus.resp_y), 32'h1F);
    check("bp_next_ops", 32'(bus.ops_done), 32'd1);
    check("bp_next_valid", 32'(bus.resp_valid), 32'd1);

    // Sparse: move rr_ptr to 3 via requester 2, then grant 2 again
    set_req(2, 3'd5, 8'hAA, 8'h0F);
    bus.req_valid = 4'b0100;
    tick();
    set_req(2, 3'd6, 8'hAA, 8'h0F);
    #1;
    check("sparse_rdy", 32'(bus.req_ready), 32'b0100);
    tick();
    check("sparse_id", 32'(bus.resp_id), 32'd2);
    check("sparse_y", 32'(bus.resp_y), 32'h5A);
    bus.req_valid = '1;
    #1;
    check("sparse_ptr", 32'(bus.req_ready), 32'b1000);
    bus.req_valid = '0;
    tick();
    tick();

    // Counter wrap
    do_reset();
    bus.resp_ready = 1'b1;
    set_req(3, 3'd0, 8'hFF, 8'h81);
    bus.req_valid = 4'b1000;
    repeat (65535) tick();
    bus.req_valid = '0;
    tick();
    check("ops_max", 32'(bus.ops_done), 32'hFFFF);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    tick();
    check("ops_wrap", 32'(bus.ops_done), 32'd0);

    // Reset while a response is held
    bus.resp_ready = 1'b0;
    set_req(0, 3'd4, 8'h0F, 8'hFF);
    bus.req_valid = 4'b0001;
    tick();
    check("mid_valid", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    check("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_y", 32'(bus.resp_y), 32'd0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) begin
      tick();
      check("no_stale", 32'(bus.resp_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
